// File: rtl/accumulator_8bit.sv
// Handshaked 8-bit signed accumulator: LOAD/ADD/SUB/CLEAR through one ripple-carry chain,
// with optional saturation, sticky overflow and a completed-operation counter.
module accumulator_8bit #(
    parameter bit          SATURATE = 1'b0,
    parameter int unsigned COUNT_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [7:0]         in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_acc,
    output logic               out_ovf,
    output logic               sticky_ovf,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    localparam logic [1:0] OpLoad  = 2'b00;
    localparam logic [1:0] OpAdd   = 2'b01;
    localparam logic [1:0] OpSub   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    state_e     state_q;
    logic [7:0] acc_q;
    logic [7:0] data_q;
    logic [1:0] op_q;

    logic       sub;
    logic [7:0] b;
    logic [7:0] sum;
    logic [8:0] carry;
    logic       add_ovf;
    logic [7:0] acc_next;
    logic       ovf_next;

    // Subtraction reuses the adder as acc + ~d + 1.
    assign sub      = (op_q == OpSub);
    assign b        = sub ? ~data_q : data_q;
    assign carry[0] = sub;

    for (genvar i = 0; i < 8; i++) begin : g_ripple
        assign sum[i]     = acc_q[i] ^ b[i] ^ carry[i];
        assign carry[i+1] = (acc_q[i] & b[i]) | (carry[i] & (acc_q[i] ^ b[i]));
    end

    // Carry into and out of the sign bit disagree exactly on signed overflow.
    assign add_ovf = carry[8] ^ carry[7];

    always_comb begin
        acc_next = acc_q;
        ovf_next = 1'b0;
        case (op_q)
            OpLoad: acc_next = data_q;
            OpAdd, OpSub: begin
                ovf_next = add_ovf;
                if (add_ovf && SATURATE) begin
                    acc_next = acc_q[7] ? 8'h80 : 8'h7F;
                end else begin
                    acc_next = sum;
                end
            end
            OpClear: acc_next = 8'h00;
            default: acc_next = acc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= 8'h00;
            data_q     <= 8'h00;
            op_q       <= OpLoad;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_acc    <= 8'h00;
            out_ovf    <= 1'b0;
            sticky_ovf <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q     <= in_op;
                        data_q   <= in_data;
                        in_ready <= 1'b0;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    acc_q     <= acc_next;
                    out_acc   <= acc_next;
                    out_ovf   <= ovf_next;
                    out_valid <= 1'b1;
                    state_q   <= StResp;
                    if (op_q == OpClear) begin
                        sticky_ovf <= 1'b0;
                        op_count   <= '0;
                    end else begin
                        sticky_ovf <= sticky_ovf | ovf_next;
                        op_count   <= op_count + 1'b1;
                    end
                end
                StResp: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accumulator_8bit.sv
// Scoreboard bench for accumulator_8bit: a wrapping and a saturating instance share stimulus.
module tb_accumulator_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_op;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready0, out_valid0, out_ovf0, sticky0;
    logic [7:0] out_acc0;
    logic [3:0] cnt0;
    logic       in_ready1, out_valid1, out_ovf1, sticky1;
    logic [7:0] out_acc1;
    logic [3:0] cnt1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] acc0;
        logic       ovf0;
        logic [7:0] acc1;
        logic       ovf1;
        logic       sticky;
        logic [3:0] cnt;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_acc0, m_acc1;
    logic       m_sticky;
    logic [3:0] m_cnt;

    always #5 clk = ~clk;

    accumulator_8bit #(.SATURATE(1'b0), .COUNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_op(in_op),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_acc(out_acc0),
        .out_ovf(out_ovf0), .sticky_ovf(sticky0), .op_count(cnt0)
    );

    accumulator_8bit #(.SATURATE(1'b1), .COUNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_op(in_op),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_acc(out_acc1),
        .out_ovf(out_ovf1), .sticky_ovf(sticky1), .op_count(cnt1)
    );

    function automatic void model(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a,
                                  input bit sat, output logic [7:0] na, output logic ov);
        logic [7:0] r;
        na = a;
        ov = 1'b0;
        case (op)
            2'b00: na = d;
            2'b01, 2'b10: begin
                if (op == 2'b01) begin
                    r  = a + d;
                    ov = (a[7] == d[7]) && (r[7] != a[7]);
                end else begin
                    r  = a - d;
                    ov = (a[7] != d[7]) && (r[7] != a[7]);
                end
                na = (ov && sat) ? (a[7] ? 8'h80 : 8'h7F) : r;
            end
            default: na = 8'h00;
        endcase
    endfunction

    // Called at the acceptance edge: advance the model and queue the expected response.
    task automatic push_expected(input logic [1:0] op, input logic [7:0] d);
        exp_t e;
        model(op, d, m_acc0, 1'b0, e.acc0, e.ovf0);
        model(op, d, m_acc1, 1'b1, e.acc1, e.ovf1);
        m_acc0 = e.acc0;
        m_acc1 = e.acc1;
        if (op == 2'b11) begin
            m_sticky = 1'b0;
            m_cnt    = 4'd0;
        end else begin
            m_sticky = m_sticky | e.ovf0;
            m_cnt    = m_cnt + 4'd1;
        end
        e.sticky = m_sticky;
        e.cnt    = m_cnt;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_acc0   = 8'h00;
        m_acc1   = 8'h00;
        m_sticky = 1'b0;
        m_cnt    = 4'd0;
        sb.delete();
    endtask

    // Waits (bounded) for out_valid, compares against the scoreboard head, then releases it.
    task automatic collect();
        exp_t e;
        int   n = 0;
        while (!out_valid0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!out_valid0 || sb.size() == 0) begin
            errors++;
            $display("FAIL collect_timeout: out_valid=%b queued=%0d, required out_valid=1 with a queued result",
                     out_valid0, sb.size());
        end else begin
            e = sb.pop_front();
            checks++;
            if ({out_acc0, out_ovf0} !== {e.acc0, e.ovf0}) begin
                errors++;
                $display("FAIL wrap_result: acc=%h ovf=%b, required acc=%h ovf=%b",
                         out_acc0, out_ovf0, e.acc0, e.ovf0);
            end
            checks++;
            if ({out_acc1, out_ovf1} !== {e.acc1, e.ovf1}) begin
                errors++;
                $display("FAIL sat_result: acc=%h ovf=%b, required acc=%h ovf=%b",
                         out_acc1, out_ovf1, e.acc1, e.ovf1);
            end
            checks++;
            if ({sticky0, cnt0, sticky1, cnt1} !== {e.sticky, e.cnt, e.sticky, e.cnt}) begin
                errors++;
                $display("FAIL status: sticky=%b/%b count=%0d/%0d, required sticky=%b count=%0d",
                         sticky0, sticky1, cnt0, cnt1, e.sticky, e.cnt);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [7:0] d);
        int n = 0;
        while (!in_ready0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready=%b, required 1", in_ready0);
        end
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        @(posedge clk);
        push_expected(op, d);
        @(negedge clk);
        in_valid = 1'b0;
        collect();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({in_ready0, out_valid0, out_acc0, out_ovf0, sticky0, cnt0} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0}
            || {in_ready1, out_valid1, out_acc1} !== {1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b vld=%b acc=%h ovf=%b sticky=%b cnt=%0d, required 1 0 00 0 0 0",
                     in_ready0, out_valid0, out_acc0, out_ovf0, sticky0, cnt0);
        end
    endtask

    task automatic test_add_overflow();
        do_op(2'b00, 8'h50);
        do_op(2'b01, 8'h40);
        checks++;
        if ({out_acc0, out_ovf0, sticky0, cnt0, out_acc1, out_ovf1} !== {8'h90, 1'b1, 1'b1, 4'd2, 8'h7F, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf_const: wrap=%h/%b sticky=%b cnt=%0d sat=%h/%b, required 90/1 1 2 7f/1",
                     out_acc0, out_ovf0, sticky0, cnt0, out_acc1, out_ovf1);
        end
    endtask

    task automatic test_sub_clear();
        do_op(2'b00, 8'h00);
        do_op(2'b10, 8'h80);
        checks++;
        if ({out_acc0, out_ovf0} !== {8'h80, 1'b1}) begin
            errors++;
            $display("FAIL sub_0x80: acc=%h ovf=%b, required 80 1", out_acc0, out_ovf0);
        end
        do_op(2'b00, 8'h05);
        do_op(2'b10, 8'h07);
        checks++;
        if ({out_acc0, out_ovf0, sticky0} !== {8'hFE, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_small: acc=%h ovf=%b sticky=%b, required fe 0 1", out_acc0, out_ovf0, sticky0);
        end
        do_op(2'b11, 8'h33);
        checks++;
        if ({out_acc0, sticky0, cnt0, out_acc1, sticky1, cnt1} !== {8'h00, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL clear: acc=%h sticky=%b cnt=%0d, required 00 0 0", out_acc0, sticky0, cnt0);
        end
    endtask

    task automatic test_timing();
        exp_t       e;
        logic [7:0] held;
        bit         bad = 1'b0;
        do_op(2'b00, 8'h10);
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_data  = 8'h22;
        @(posedge clk);
        push_expected(2'b01, 8'h22);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if ({out_valid0, in_ready0} !== 2'b00) begin
            errors++;
            $display("FAIL exec_phase: out_valid=%b in_ready=%b, required 0 0", out_valid0, in_ready0);
        end
        @(negedge clk);
        checks++;
        if (out_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL out_valid_latency: out_valid=%b, required 1", out_valid0);
        end
        held = out_acc0;
        // A second command presented while the result is pending must be ignored.
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_data  = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_acc0 !== held || in_ready0 !== 1'b0 || out_valid0 !== 1'b1) bad = 1'b1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL resp_hold: acc=%h in_ready=%b out_valid=%b, required acc=%h 0 1",
                     out_acc0, in_ready0, out_valid0, held);
        end
        e = sb.pop_front();
        checks++;
        if (out_acc0 !== e.acc0 || out_acc0 !== 8'h32) begin
            errors++;
            $display("FAIL timed_result: acc=%h, required %h", out_acc0, e.acc0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({in_ready0, out_valid0} !== 2'b10) begin
            errors++;
            $display("FAIL back_to_idle: in_ready=%b out_valid=%b, required 1 0", in_ready0, out_valid0);
        end
        @(negedge clk);
        checks++;
        if ({in_ready0, out_valid0} !== 2'b10) begin
            errors++;
            $display("FAIL ignored_cmd: in_ready=%b out_valid=%b, required 1 0", in_ready0, out_valid0);
        end
    endtask

    task automatic test_sat_edges();
        do_op(2'b00, 8'h80);
        do_op(2'b01, 8'hFF);
        checks++;
        if ({out_acc1, out_ovf1} !== {8'h80, 1'b1}) begin
            errors++;
            $display("FAIL sat_neg: acc=%h ovf=%b, required 80 1", out_acc1, out_ovf1);
        end
        do_op(2'b00, 8'h7F);
        do_op(2'b01, 8'h01);
        checks++;
        if ({out_acc0, out_ovf0} !== {8'h80, 1'b1}) begin
            errors++;
            $display("FAIL wrap_pos: acc=%h ovf=%b, required 80 1", out_acc0, out_ovf0);
        end
    endtask

    task automatic test_count_wrap();
        do_op(2'b11, 8'h00);
        for (int i = 0; i < 16; i++) do_op(2'b01, 8'h01);
        checks++;
        if ({out_acc0, cnt0, sticky0} !== {8'h10, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL count_wrap: acc=%h cnt=%0d sticky=%b, required 10 0 0", out_acc0, cnt0, sticky0);
        end
    endtask

    task automatic test_rst_mid_exec();
        do_op(2'b00, 8'h44);
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_data  = 8'h01;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        checks++;
        if ({in_ready0, out_valid0, out_acc0, out_ovf0, sticky0, cnt0} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL rst_mid_exec: rdy=%b vld=%b acc=%h ovf=%b sticky=%b cnt=%0d, required 1 0 00 0 0 0",
                     in_ready0, out_valid0, out_acc0, out_ovf0, sticky0, cnt0);
        end
        @(negedge clk);
        checks++;
        if (out_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL rst_discard: out_valid=%b, required 0", out_valid0);
        end
        do_op(2'b01, 8'h03);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_data   = 8'h00;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_add_overflow();
        test_sub_clear();
        test_timing();
        test_sat_edges();
        test_count_wrap();
        test_rst_mid_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
